// File: rtl/floor_request_arbiter_if.sv
// Next-floor request handshake between the call arbiter and the elevator controller FSM.
// The arbiter drives valid/floor. The controller drives ready.
interface floor_request_arbiter_if;
  logic       req_valid;
  logic [1:0] req_floor;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_floor,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_floor,
    output req_ready
  );
endinterface

// File: rtl/floor_request_arbiter.sv
// Debounced floor buttons -> pending calls -> nearest-floor request; offer appears 2 cycles after a call, at least 2 idle cycles between offers.
// Backpressure: an offer is held unchanged until req_ready; new presses keep accumulating in pending meanwhile.
module floor_request_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           g_f,
  input  logic                           f_f,
  input  logic                           s_f,
  input  logic [1:0]                     c_f,
  input  logic                           busy,
  floor_request_arbiter_if.master        req,
  output logic [2:0]                     pending
);

  localparam logic [16:0] DB_LIMIT = 17'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2
  } state_e;

  logic [2:0]  raw;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  stable_q, stable_d;
  logic [2:0]  stable_prev_q;
  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];
  logic [16:0] cnt_inc [3];

  logic [2:0]  press;
  logic [1:0]  c_eff;
  logic [2:0]  drop_mask;
  logic [2:0]  set_mask;
  logic [2:0]  clr_mask;
  logic        hs;
  logic [2:0]  pending_q, pending_d;

  state_e      state_q, state_d;
  logic [1:0]  req_floor_q, req_floor_d;
  logic        last_dir_up_q, last_dir_up_d;
  logic [1:0]  best_floor;
  logic [1:0]  best_dist;

  function automatic logic [1:0] floor_dist(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign raw = {s_f, f_f, g_f};

  // Debounce: the level must differ from stable for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_inc[i]  = {1'b0, cnt_q[i]} + 17'd1;
      stable_d[i] = stable_q[i];
      cnt_d[i]    = 16'd0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_inc[i] >= DB_LIMIT) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_inc[i][15:0];
        end
      end
    end
  end

  assign press     = stable_q & ~stable_prev_q;
  assign c_eff     = (c_f == 2'd3) ? 2'd0 : c_f;
  assign drop_mask = busy ? 3'b000 : (3'b001 << c_eff);
  assign set_mask  = press & ~drop_mask;
  assign hs        = req.req_valid & req.req_ready;
  assign clr_mask  = hs ? (3'b001 << req_floor_q) : 3'b000;
  assign pending_d = (pending_q & ~clr_mask) | set_mask;

  // Nearest pending floor; the only possible tie (c_f=1, floors 0 and 2) follows last direction.
  always_comb begin
    best_floor = 2'd0;
    best_dist  = 2'd3;
    for (int f = 0; f < 3; f++) begin
      if (pending_q[f]) begin
        if ((floor_dist(2'(f), c_eff) < best_dist) ||
            ((floor_dist(2'(f), c_eff) == best_dist) && last_dir_up_q)) begin
          best_floor = 2'(f);
          best_dist  = floor_dist(2'(f), c_eff);
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    req_floor_d   = req_floor_q;
    last_dir_up_d = last_dir_up_q;
    case (state_q)
      IDLE: begin
        if (pending_q != 3'b000) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (pending_q == 3'b000) begin
          state_d = IDLE;
        end else begin
          req_floor_d = best_floor;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (req.req_ready) begin
          if (req_floor_q > c_eff) begin
            last_dir_up_d = 1'b1;
          end else if (req_floor_q < c_eff) begin
            last_dir_up_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      stable_q      <= 3'b000;
      stable_prev_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= 16'd0;
      end
      pending_q     <= 3'b000;
      state_q       <= IDLE;
      req_floor_q   <= 2'd0;
      last_dir_up_q <= 1'b1;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q     <= pending_d;
      state_q       <= state_d;
      req_floor_q   <= req_floor_d;
      last_dir_up_q <= last_dir_up_d;
    end
  end

  assign req.req_valid = (state_q == OFFER);
  assign req.req_floor = req_floor_q;
  assign pending       = pending_q;

endmodule
